// File: rtl/sam_clk_mon_if.sv
// rtl/sam_clk_mon_if.sv - sample-clock monitor signal bundle
//
// Purpose: groups the asynchronous sample clock input and the monitor's
// status outputs so the demodulator side can be wired as one port.
//
// Signals:
//   clk_i   sample clock, asynchronous to the system clock
//   sam_en  one-cycle strobe per detected rising edge of clk_i
//   period  last measured edge-to-edge period, in system clock cycles
//   locked  high while the sample clock period is stable and in tolerance
//   err     one-cycle pulse on an out-of-tolerance period or a timeout
//
// Modports:
//   master  the monitor itself (consumes clk_i, drives status)
//   slave   the surrounding logic (drives clk_i, consumes status)

interface sam_clk_mon_if #(
   parameter int CNT_W = 8
);

   logic             clk_i;
   logic             sam_en;
   logic [CNT_W-1:0] period;
   logic             locked;
   logic             err;

   modport master (
      input  clk_i,
      output sam_en,
      output period,
      output locked,
      output err
   );

   modport slave (
      output clk_i,
      input  sam_en,
      input  period,
      input  locked,
      input  err
   );

endinterface

// File: rtl/sam_clk_mon.sv
// rtl/sam_clk_mon.sv - sample-clock edge strobe, period measurement and lock monitor
//
// Purpose: brings the divided sample clock into the clk domain through a
// two-flop synchroniser, turns each rising edge into a one-cycle sam_en
// strobe, measures the edge-to-edge period in clk cycles and tracks whether
// that period is stable and within tolerance (locked / err).
//
// Optional feature: define SAM_MON_GATE_EN to restrict sam_en to edges that
// leave the FSM in LOCKED (edges in LOCKED plus the edge that enters it).
// Without the macro sam_en fires on every detected edge.
//
// Parameters:
//   EXP_PERIOD  expected clk_i period in clk cycles
//   TOL         allowed deviation from EXP_PERIOD in cycles
//   LOCK_CNT    consecutive good periods required for lock
//   CNT_W       width of the period counter and of period
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   sam_clk_mon_if master modport (clk_i in; sam_en, period,
//         locked, err out; all outputs registered)

module sam_clk_mon #(
   parameter int EXP_PERIOD = 50,
   parameter int TOL        = 2,
   parameter int LOCK_CNT   = 4,
   parameter int CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   sam_clk_mon_if.master        bus
);

   // Acceptance window and timeout limit for the measured period.
   localparam logic [CNT_W-1:0] PER_LO  = CNT_W'(EXP_PERIOD - TOL);
   localparam logic [CNT_W-1:0] PER_HI  = CNT_W'(EXP_PERIOD + TOL);
   localparam logic [CNT_W-1:0] TLIM    = CNT_W'(EXP_PERIOD + TOL + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // good counts 0..LOCK_CNT; GOOD_LAST is the value one short of lock.
   localparam int               GOOD_W    = $clog2(LOCK_CNT + 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
   localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Synchroniser and edge-detect delay register.
   logic s1;
   logic s2;
   logic s3;

   logic [CNT_W-1:0]  cnt_q;
   state_t            state_q;
   state_t            state_d;
   logic [GOOD_W-1:0] good_q;
   logic [GOOD_W-1:0] good_d;

   // Registered outputs and their next values.
   logic             sam_en_q;
   logic             sam_en_d;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] period_d;
   logic             locked_q;
   logic             locked_d;
   logic             err_q;
   logic             err_d;

   logic edge_det;
   logic period_ok;
   logic timeout;

   assign edge_det  = s2 & ~s3;
   // cnt holds the running period; on an edge cycle it is the measurement.
   assign period_ok = (cnt_q >= PER_LO) && (cnt_q <= PER_HI);
   // cnt saturates above TLIM, so equality is seen at most once per stall.
   assign timeout   = (cnt_q == TLIM);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         s3       <= 1'b0;
         cnt_q    <= '0;
         state_q  <= SEARCH;
         good_q   <= '0;
         sam_en_q <= 1'b0;
         period_q <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         s1 <= bus.clk_i;
         s2 <= s1;
         s3 <= s2;

         if (edge_det) begin
            cnt_q <= CNT_ONE;
         end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
         end

         state_q  <= state_d;
         good_q   <= good_d;
         sam_en_q <= sam_en_d;
         period_q <= period_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      period_d = period_q;
      locked_d = locked_q;
      err_d    = 1'b0;

      case (state_q)
         SEARCH: begin
            // First edge only opens a measurement window; nothing to report.
            if (edge_det) begin
               state_d = TRACK;
               good_d  = '0;
            end
         end

         TRACK: begin
            // An edge wins over a coincident timeout: cnt == TLIM is then
            // simply an out-of-tolerance period.
            if (edge_det) begin
               period_d = cnt_q;
               if (period_ok) begin
                  good_d = good_q + GOOD_ONE;
                  if (good_q == GOOD_LAST) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  good_d = '0;
                  err_d  = 1'b1;
               end
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = SEARCH;
            end
         end

         LOCKED: begin
            if (edge_det) begin
               period_d = cnt_q;
               if (!period_ok) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  good_d   = '0;
                  state_d  = TRACK;
               end
            end else if (timeout) begin
               err_d    = 1'b1;
               locked_d = 1'b0;
               state_d  = SEARCH;
            end
         end

         default: begin
            state_d  = SEARCH;
            good_d   = '0;
            locked_d = 1'b0;
         end
      endcase

`ifdef SAM_MON_GATE_EN
      // Only edges that end up in LOCKED reach downstream logic.
      sam_en_d = edge_det && (state_d == LOCKED);
`else
      sam_en_d = edge_det;
`endif
   end

   assign bus.sam_en = sam_en_q;
   assign bus.period = period_q;
   assign bus.locked = locked_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_sam_clk_mon.sv
// tb/tb_sam_clk_mon.sv - directed self-checking bench for sam_clk_mon

module tb_sam_clk_mon;

`ifdef SAM_MON_GATE_EN
   localparam bit GATE = 1'b1;
`else
   localparam bit GATE = 1'b0;
`endif

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_TRACK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int errors   = 0;
   int err_seen = 0;
   int dbl      = 0;
   int e0       = 0;
   logic prev_sam = 1'b0;

   sam_clk_mon_if #(.CNT_W(8)) bus ();

   sam_clk_mon #(
      .EXP_PERIOD (50),
      .TOL        (2),
      .LOCK_CNT   (4),
      .CNT_W      (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #10 clk = ~clk;

   task automatic step();
      @(negedge clk);
      if (bus.err === 1'b1) err_seen++;
      if (bus.sam_en === 1'b1 && prev_sam === 1'b1) dbl++;
      prev_sam = bus.sam_en;
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Raise clk_i now; the result is visible on the 3rd sample after.
   task automatic rise(input string tag, input logic [7:0] exp_period,
                       input logic exp_locked, input logic exp_err,
                       input logic [1:0] exp_state);
      bus.clk_i = 1'b1;
      hold(2);
      chk({tag, ".early_sam"}, bus.sam_en, 0);
      step();
      chk({tag, ".sam_en"}, bus.sam_en, GATE ? exp_locked : 1'b1);
      chk({tag, ".period"}, bus.period, exp_period);
      chk({tag, ".locked"}, bus.locked, exp_locked);
      chk({tag, ".err"},    bus.err,    exp_err);
      chk({tag, ".state"},  dut.state_q, exp_state);
      step();
      chk({tag, ".sam_width"}, bus.sam_en, 0);
      chk({tag, ".err_width"}, bus.err,    0);
   endtask

   // Finish the current period so the next rise is p samples after the last.
   task automatic rest(input int p);
      hold(21);
      bus.clk_i = 1'b0;
      hold(p - 25);
   endtask

   initial begin
      bus.clk_i = 1'b0;
      rst = 1'b1;
      hold(3);
      chk("rst.sam_en", bus.sam_en, 0);
      chk("rst.period", bus.period, 0);
      chk("rst.locked", bus.locked, 0);
      chk("rst.err",    bus.err,    0);
      chk("rst.state",  dut.state_q, ST_SEARCH);
      rst = 1'b0;
      hold(5);

      // Lock-up at period 50
      rise("lk1", 8'd0,  1'b0, 1'b0, ST_TRACK);  rest(50);
      rise("lk2", 8'd50, 1'b0, 1'b0, ST_TRACK);  rest(50);
      rise("lk3", 8'd50, 1'b0, 1'b0, ST_TRACK);  rest(50);
      rise("lk4", 8'd50, 1'b0, 1'b0, ST_TRACK);  rest(50);
      rise("lk5", 8'd50, 1'b1, 1'b0, ST_LOCKED);

      // Tolerance boundary on the high side
      rest(52);
      rise("tol52", 8'd52, 1'b1, 1'b0, ST_LOCKED);
      rest(53);
      rise("tol53", 8'd53, 1'b0, 1'b1, ST_TRACK);
      rest(50); rise("rl1", 8'd50, 1'b0, 1'b0, ST_TRACK);
      rest(50); rise("rl2", 8'd50, 1'b0, 1'b0, ST_TRACK);
      rest(50); rise("rl3", 8'd50, 1'b0, 1'b0, ST_TRACK);
      rest(50); rise("rl4", 8'd50, 1'b1, 1'b0, ST_LOCKED);

      // Stopped clock: cnt reaches 53 on the 55th sample after the rise
      hold(21);
      bus.clk_i = 1'b0;
      hold(30);
      chk("stop.err_before",    bus.err,    0);
      chk("stop.locked_before", bus.locked, 1);
      step();
      chk("stop.err",    bus.err,    1);
      chk("stop.locked", bus.locked, 0);
      chk("stop.state",  dut.state_q, ST_SEARCH);
      e0 = err_seen;
      hold(500);
      chk("stop.no_more_err", err_seen - e0, 0);

      // Restart: first edge keeps the old period
      rise("rs1", 8'd50, 1'b0, 1'b0, ST_TRACK);  rest(50);
      rise("rs2", 8'd50, 1'b0, 1'b0, ST_TRACK);  rest(50);
      rise("rs3", 8'd50, 1'b0, 1'b0, ST_TRACK);  rest(50);
      rise("rs4", 8'd50, 1'b0, 1'b0, ST_TRACK);  rest(50);
      rise("rs5", 8'd50, 1'b1, 1'b0, ST_LOCKED);

      // Edge coincident with cnt == TLIM, from LOCKED and then from TRACK
      rest(53);
      rise("sim_lk", 8'd53, 1'b0, 1'b1, ST_TRACK);
      rest(53);
      e0 = err_seen;
      rise("sim_tr", 8'd53, 1'b0, 1'b1, ST_TRACK);
      chk("sim_tr.one_err", err_seen - e0, 1);

      // Tolerance boundary on the low side
      rest(48); rise("lo48", 8'd48, 1'b0, 1'b0, ST_TRACK);
      rest(47); rise("lo47", 8'd47, 1'b0, 1'b1, ST_TRACK);

      // Relock, then reset mid-lock
      rest(50); rise("m1", 8'd50, 1'b0, 1'b0, ST_TRACK);
      rest(50); rise("m2", 8'd50, 1'b0, 1'b0, ST_TRACK);
      rest(50); rise("m3", 8'd50, 1'b0, 1'b0, ST_TRACK);
      rest(50); rise("m4", 8'd50, 1'b1, 1'b0, ST_LOCKED);
      hold(21);
      bus.clk_i = 1'b0;
      hold(10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst.sam_en", bus.sam_en, 0);
      chk("mrst.period", bus.period, 0);
      chk("mrst.locked", bus.locked, 0);
      chk("mrst.err",    bus.err,    0);
      chk("mrst.state",  dut.state_q, ST_SEARCH);
      hold(14);
      rise("post_rst", 8'd0, 1'b0, 1'b0, ST_TRACK);
      hold(5);

      chk("sam_never_back_to_back", dbl, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
